// File: rtl/lfsr_checker_if.sv
// Serial PRBS checker bus: received bit stream with qualifiers in, lock/error status out.
interface lfsr_checker_if;
    logic        enable;
    logic        din;
    logic        clear;
    logic        locked;
    logic        error;
    logic [15:0] err_count;

    // Handshake: there is no back-pressure. A bit is transferred on every rising
    // clock edge where enable=1; din is ignored otherwise. clear is level-sampled.
    modport master (
        output enable, din, clear,
        input  locked, error, err_count
    );

    modport slave (
        input  enable, din, clear,
        output locked, error, err_count
    );
endinterface

// File: rtl/lfsr_checker.sv
// Fibonacci-LFSR PRBS checker: seeds from the received stream, then free-runs and counts mismatches.
// Optional macro LFSR_CHK_AUTORESYNC_EN: reseed automatically after THRESH errors within one window.
module lfsr_checker #(
    parameter int unsigned      WIDTH  = 7,
    parameter logic [WIDTH-1:0] TAPS   = 7'b1100000,
    parameter int unsigned      WIN    = 64,
    parameter int unsigned      THRESH = 8
) (
    input logic          clock,
    input logic          reset,
    lfsr_checker_if.slave bus
);

    localparam int unsigned SCW = $clog2(WIDTH + 1);
    localparam int unsigned WCW = $clog2(WIN);
    localparam int unsigned EW  = $clog2(WIN + 1);

    localparam logic [SCW-1:0] SEED_LAST = SCW'(WIDTH - 1);
    localparam logic [WCW-1:0] WIN_LAST  = WCW'(WIN - 1);
    localparam logic [EW-1:0]  THRESH_V  = EW'(THRESH);

    typedef enum logic {
        ST_SEED   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [SCW-1:0]   seed_cnt_q, seed_cnt_d;
    logic [WCW-1:0]   win_cnt_q, win_cnt_d;
    logic [EW-1:0]    win_err_q, win_err_d;
    logic [15:0]      err_count_q, err_count_d;
    logic             error_q, error_d;

    logic             expected;
    logic             mismatch;
    logic [WIDTH-1:0] seed_next;
    logic [EW-1:0]    win_err_inc;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        seed_cnt_d  = seed_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        error_d     = 1'b0;
        mismatch    = 1'b0;

        expected    = ^(s_q & TAPS);
        seed_next   = {s_q[WIDTH-2:0], bus.din};
        win_err_inc = win_err_q + EW'(1);

        if (bus.enable) begin
            case (state_q)
                ST_SEED: begin
                    s_d = seed_next;
                    if (seed_cnt_q == SEED_LAST) begin
                        seed_cnt_d = '0;
                        // An all-zero seed would lock the LFSR at zero forever; collect another.
                        if (seed_next != '0) begin
                            state_d   = ST_LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + SCW'(1);
                    end
                end
                ST_LOCKED: begin
                    s_d       = {s_q[WIDTH-2:0], expected};
                    mismatch  = (bus.din != expected);
                    error_d   = mismatch;
                    win_cnt_d = win_cnt_q + WCW'(1);
                    if (win_cnt_q == WIN_LAST) begin
                        win_err_d = '0;
                    end else if (mismatch && (win_err_q != THRESH_V)) begin
                        win_err_d = win_err_inc;
                    end
`ifdef LFSR_CHK_AUTORESYNC_EN
                    if (mismatch && (win_err_inc == THRESH_V)) begin
                        state_d    = ST_SEED;
                        seed_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                    end
`else
                    // Loss of lock is only counted; the checker stays locked until reset.
`endif
                end
                default: state_d = ST_SEED;
            endcase
        end

        if (bus.clear) begin
            err_count_d = '0;
        end else if (mismatch && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_SEED;
            s_q         <= '0;
            seed_cnt_q  <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            seed_cnt_q  <= seed_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            error_q     <= error_d;
        end
    end

    // The state register doubles as the registered lock indicator and exposes the FSM.
    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.error     = error_q;
    assign bus.err_count = err_count_q;

endmodule
